// File: rtl/vend_balance_if.sv
// Handshake and status bundle between the coin/selection front end and vend_balance_ctrl.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; ready never depends on the outputs it gates.
interface vend_balance_if #(
  parameter int WIDTH = 5
);
  logic             coin_valid;
  logic [WIDTH-1:0] coin_value;
  logic             coin_ready;
  logic             buy_valid;
  logic [WIDTH-1:0] buy_price;
  logic             buy_ready;
  logic             cancel;
  logic [WIDTH-1:0] credit;
  logic             vend;
  logic             deny;
  logic             coin_reject;
  logic             change_pulse;
  logic             busy;

  modport master (
    output coin_valid, coin_value, buy_valid, buy_price, cancel,
    input  coin_ready, buy_ready, credit, vend, deny, coin_reject, change_pulse, busy
  );

  modport slave (
    input  coin_valid, coin_value, buy_valid, buy_price, cancel,
    output coin_ready, buy_ready, credit, vend, deny, coin_reject, change_pulse, busy
  );
endinterface

// File: rtl/vend_balance_ctrl.sv
// Credit/purchase controller: signed credit balance, coin deposits, purchases decided by negate-add-sign test.
// Define VEND_CHANGE_RETURN_EN to return all remaining credit automatically after every vend.
module vend_balance_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  vend_balance_if.slave  bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MAX_CREDIT = {2'b00, {(WIDTH-1){1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic             vend_q, vend_d;
  logic             deny_q, deny_d;
  logic             reject_q, reject_d;

  logic [WIDTH:0]   coin_sum;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] diff;
  logic             is_negative;

  // Credit is never negative, so a one-bit-wider unsigned sum detects overflow past the signed maximum.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign neg         = (~price_q) + ONE;
  assign diff        = credit_q + neg;
  assign is_negative = diff[WIDTH-1] | price_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      vend_q   <= 1'b0;
      deny_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      vend_q   <= vend_d;
      deny_q   <= deny_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    vend_d   = 1'b0;
    deny_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cancel) begin
          state_d = CHANGE;
        end else if (bus.coin_valid) begin
          if (coin_sum <= MAX_CREDIT) begin
            credit_d = coin_sum[WIDTH-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end else if (bus.buy_valid) begin
          price_d = bus.buy_price;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!is_negative) begin
          credit_d = diff;
          vend_d   = 1'b1;
`ifdef VEND_CHANGE_RETURN_EN
          state_d  = CHANGE;
`else
          state_d  = IDLE;
`endif
        end else begin
          deny_d  = 1'b1;
          state_d = IDLE;
        end
      end
      CHANGE: begin
        // One unit leaves per cycle; the cycle that sees zero is the silent exit cycle.
        if (credit_q != '0) begin
          credit_d = credit_q - ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.coin_ready   = (state_q == IDLE);
  assign bus.buy_ready    = (state_q == IDLE) && !bus.coin_valid && !bus.cancel;
  assign bus.busy         = (state_q != IDLE);
  assign bus.change_pulse = (state_q == CHANGE) && (credit_q != '0);
  assign bus.credit       = credit_q;
  assign bus.vend         = vend_q;
  assign bus.deny         = deny_q;
  assign bus.coin_reject  = reject_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_vend_balance_ctrl.sv
// Self-checking bench for vend_balance_ctrl: transaction-level credit model feeding a per-cycle expected-output queue.
module tb_vend_balance_ctrl;

  localparam int W = 5;
`ifdef VEND_CHANGE_RETURN_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] credit;
    logic         vend;
    logic         deny;
    logic         reject;
    logic         pulse;
    logic         busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  exp_t       exp_q[$];
  int         n_pass;
  int         n_total;
  int         m_credit;

  vend_balance_if #(.WIDTH(W)) bus ();

  vend_balance_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input int c, input bit v, input bit d, input bit r, input bit p, input bit b);
    exp_t e;
    e.credit = W'(c);
    e.vend   = v;
    e.deny   = d;
    e.reject = r;
    e.pulse  = p;
    e.busy   = b;
    return e;
  endfunction

  // scoreboard: one expected record per cycle, checked away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = {bus.credit, bus.vend, bus.deny, bus.coin_reject, bus.change_pulse, bus.busy};
      check("outputs", 32'(a), 32'(e));
      check("ready", 32'({bus.coin_ready, bus.buy_ready, state_dbg == 2'd0}),
            32'({!e.busy, !e.busy && !bus.coin_valid && !bus.cancel, !e.busy}));
    end
  end

  // driver tasks
  task automatic tick(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.buy_valid  = 1'b0;
    bus.buy_price  = '0;
    bus.cancel     = 1'b0;
  endtask

  task automatic noise();
    bus.coin_valid = 1'($urandom_range(0, 1));
    bus.coin_value = W'($urandom_range(0, 31));
    bus.buy_valid  = 1'($urandom_range(0, 1));
    bus.buy_price  = W'($urandom_range(0, 31));
    bus.cancel     = 1'($urandom_range(0, 1));
  endtask

  task automatic op_idle();
    clear_in();
    tick(mk(m_credit, 0, 0, 0, 0, 0));
  endtask

  task automatic op_coin(input int v, input bit with_buy, input int price);
    bit rej;
    clear_in();
    bus.coin_valid = 1'b1;
    bus.coin_value = W'(v);
    bus.buy_valid  = with_buy;
    bus.buy_price  = W'(price);
    rej = (m_credit + v) > 15;
    if (!rej) m_credit += v;
    tick(mk(m_credit, 0, 0, rej, 0, 0));
  endtask

  // Caller has already pushed the first CHANGE cycle showing m_credit.
  task automatic change_tail();
    int c;
    c = m_credit;
    while (c > 0) begin
      c--;
      noise();
      tick(mk(c, 0, 0, 0, c != 0, 1));
    end
    m_credit = 0;
    noise();
    tick(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic op_cancel();
    clear_in();
    bus.cancel     = 1'b1;
    bus.coin_valid = 1'($urandom_range(0, 1));
    bus.coin_value = W'($urandom_range(1, 5));
    bus.buy_valid  = 1'($urandom_range(0, 1));
    tick(mk(m_credit, 0, 0, 0, m_credit != 0, 1));
    change_tail();
  endtask

  task automatic op_buy(input int price);
    bit ok;
    clear_in();
    bus.buy_valid = 1'b1;
    bus.buy_price = W'(price);
    tick(mk(m_credit, 0, 0, 0, 0, 1));
    noise();
    ok = (price < 16) && (price <= m_credit);
    if (ok) m_credit -= price;
    if (ok && CR) begin
      tick(mk(m_credit, 1, 0, 0, m_credit != 0, 1));
      change_tail();
    end else begin
      tick(mk(m_credit, ok, !ok, 0, 0, 0));
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    m_credit = 0;
    rst_n    = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("reset_credit", 32'(bus.credit), 32'd0);
    check("reset_flags", 32'({bus.vend, bus.deny, bus.coin_reject, bus.change_pulse, bus.busy}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // coins 5 + 10, buy 12
    op_coin(5, 0, 0);
    op_coin(10, 0, 0);
    op_buy(12);
    check("t1_credit", 32'(bus.credit), CR ? 32'd0 : 32'd3);
    check("t1_vend", 32'(bus.vend), CR ? 32'd0 : 32'd1);

    // credit 5, buy 7 -> deny
    op_cancel();
    op_coin(5, 0, 0);
    op_buy(7);
    check("t2_deny", 32'({bus.deny, bus.vend}), 32'b10);
    check("t2_credit", 32'(bus.credit), 32'd5);

    // overflow reject then accept
    op_cancel();
    op_coin(10, 0, 0);
    op_coin(10, 0, 0);
    check("t3_reject", 32'({bus.coin_reject, bus.credit}), 32'({1'b1, 5'd10}));
    op_coin(5, 0, 0);
    check("t3_credit15", 32'({bus.coin_reject, bus.credit}), 32'({1'b0, 5'd15}));

    // credit 4 cancel
    op_cancel();
    op_coin(4, 0, 0);
    op_cancel();
    check("t4_done", 32'({bus.busy, bus.credit}), 32'd0);

    // price 0 and price with MSB set
    op_coin(6, 0, 0);
    op_buy(0);
    check("t5_price0", 32'(bus.credit), CR ? 32'd0 : 32'd6);
    op_cancel();
    op_coin(15, 0, 0);
    op_buy(16);
    check("t5_msb_deny", 32'({bus.deny, bus.credit}), 32'({1'b1, 5'd15}));

    // same-cycle coin + buy: coin first
    op_cancel();
    op_coin(8, 1, 8);
    check("t6_coin_first", 32'({bus.busy, bus.credit}), 32'({1'b0, 5'd8}));
    op_buy(8);
    check("t6_credit", 32'(bus.credit), 32'd0);

    // reset during CHANGE
    op_coin(3, 0, 0);
    clear_in();
    bus.cancel = 1'b1;
    tick(mk(3, 0, 0, 0, 1, 1));
    noise();
    tick(mk(2, 0, 0, 0, 1, 1));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t7_rst_credit", 32'(bus.credit), 32'd0);
    check("t7_rst_flags", 32'({bus.change_pulse, bus.busy, state_dbg}), 32'd0);
    m_credit = 0;
    op_idle();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3)
        op_coin(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8),
                1'($urandom_range(0, 1)), $urandom_range(0, 15));
      else if (sel <= 6)
        op_buy(($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15));
      else if (sel == 7)
        op_cancel();
      else
        op_idle();
    end
    op_idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vend_balance_ctrl.md
# vend_balance_ctrl

- Sequential credit/purchase controller for the vending machine.
- Holds a WIDTH-bit signed credit balance and accepts coin deposits and purchase requests over valid/ready handshakes.
- Decides each purchase by adding the two's-complement negation of the price to the credit and testing the sign bit.
- Sits between the coin/selection front end and the dispense/change actuators, and is the only block that sequences the negate/compare datapath.

## Interface
- WIDTH, 5: credit/price/coin width; signed credit range -2^(WIDTH-1)..2^(WIDTH-1)-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- coin_valid  in  1  coin offered.
- coin_value  in  WIDTH  coin value, unsigned.
- coin_ready  out  1  = (state==IDLE).
- buy_valid  in  1  purchase requested.
- buy_price  in  WIDTH  price, unsigned.
- buy_ready  out  1  = (state==IDLE) && !coin_valid && !cancel.
- cancel  in  1  return all credit; sampled only in IDLE.
- credit  out  WIDTH  current balance, registered.
- vend  out  1  one-cycle pulse: purchase granted.
- deny  out  1  one-cycle pulse: insufficient credit.
- coin_reject  out  1  one-cycle pulse: coin refused (overflow).
- change_pulse  out  1  one coin unit returned this cycle.
- busy  out  1  = (state!=IDLE).

## Operation
- States: IDLE, CHECK, CHANGE.
- Reset: state=IDLE; credit=0; price_q=0; vend=deny=coin_reject=0; change_pulse=0; busy=0.
- IDLE priority: cancel > coin > buy.
  - cancel: go to CHANGE.
  - Coin accepted (coin_valid): if credit+coin_value ≤ 2^(WIDTH-1)-1, credit += coin_value. Otherwise pulse coin_reject next cycle and leave credit unchanged. coin_value=0 is accepted as a no-op.
  - Buy accepted (buy_valid && buy_ready): latch price_q=buy_price and go to CHECK.
- CHECK:
  - neg = (~price_q)+1, truncated to WIDTH.
  - diff = credit + neg, truncated to WIDTH.
  - is_negative = diff[WIDTH-1] | price_q[WIDTH-1]. A price with MSB set is always denied.
  - If !is_negative: credit<=diff, vend pulse. Otherwise deny pulse, credit unchanged.
  - Next state: IDLE, or CHANGE on vend when the change-return feature is compiled in.
- CHANGE: change_pulse = (credit!=0), a Moore output. Each such cycle credit decrements by 1. When credit==0 the state returns to IDLE; the exit cycle has no pulse.
- Price 0: neg=0 → vend, credit unchanged.
- Inputs are ignored while busy. A valid held high is accepted on the first IDLE cycle.

## Timing
- Coin: accepted at edge N; credit updated, or coin_reject high, during cycle N+1.
- Buy: accepted at edge N; CHECK during N+1; vend/deny high and credit updated during N+2; busy high during N+1.
- Change: k units of credit give k consecutive change_pulse cycles plus one exit cycle, so busy lasts k+1 cycles. credit=0 gives 1 busy cycle and no pulse.
- Next buy acceptance: earliest the cycle after vend/deny (no change return).
- Reset mid-operation: everything returns to reset values immediately; a pending vend or remaining change is discarded.

## Configuration
- VEND_CHANGE_RETURN_EN defined: after every vend, CHANGE runs automatically and returns the remaining credit. credit is 0 when IDLE resumes.
- Not defined: after a vend, return to IDLE with the remaining credit retained for further purchases. Change is returned only via cancel.

## Test plan
- Coins 5 then 10, buy 12.
  - Macro off: vend pulse 2 cycles after acceptance, credit=3.
  - Macro on: then 3 change_pulse cycles, credit=0, busy low.
- Credit 5, buy 7:
  - internally diff=5'b11110 (-2);
  - deny pulse at N+2;
  - credit stays 5;
  - no vend.
- Credit 10, coin 10 → coin_reject pulse, credit 10; then coin 5 → credit 15, no reject.
- Credit 4, cancel → busy 5 cycles, exactly 4 change_pulse, credit 0. Buy and coin offered during CHANGE are not accepted (ready low).
- buy_price=0 at credit 6 → vend, credit 6. buy_price=5'b10000 at credit 15 → deny.
- Same-cycle coin_valid+buy_valid at credit 0 (coin 8, price 8): coin taken first (buy_ready low), buy accepted next cycle, vend, credit 0.
- rst_n low during CHANGE with credit 3 → immediately credit=0, IDLE, change_pulse=0, busy=0.
